// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; legal ops respond L+1 cycles after accept, rejects after 1.
// Requesters are backpressured by ready (IDLE only); responses are single-cycle pulses with no backpressure.
module alu_arbiter #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_srcA,
  output logic [DATA_W-1:0] alu_srcB,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);
  localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAX_L > 1) ? $clog2(MAX_L) : 1;
  localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_DIV = CTRL_W'(5);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              state;
  logic                last_grant;
  logic                gnt_id;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   result_q;
  logic                err_q;

  logic                any_vld;
  logic                gnt_sel;
  logic                xfer;
  logic                reject;
  logic [CTRL_W-1:0]   sel_ctrl;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [CNT_W-1:0]    lat_m1;

  function automatic logic is_legal(input logic [CTRL_W-1:0] c);
    case (c)
      CTRL_W'(1), CTRL_W'(2), CTRL_W'(3), CTRL_W'(4), CTRL_W'(5),
      CTRL_W'(6), CTRL_W'(9), CTRL_W'(10), CTRL_W'(11), CTRL_W'(12): is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  // On a tie the requester that did not win last time gets the grant.
  assign any_vld  = req0_valid | req1_valid;
  assign gnt_sel  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign xfer     = (state == IDLE) && any_vld;
  assign sel_ctrl = gnt_sel ? req1_ctrl : req0_ctrl;
  assign sel_a    = gnt_sel ? req1_a : req0_a;
  assign sel_b    = gnt_sel ? req1_b : req0_b;
  assign reject   = !is_legal(sel_ctrl) || ((sel_ctrl == OP_DIV) && (sel_b == '0));
  assign lat_m1   = (sel_ctrl == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) :
                    (sel_ctrl == OP_DIV) ? CNT_W'(DIV_CYCLES - 1) : '0;

  assign req0_ready = xfer && !gnt_sel;
  assign req1_ready = xfer && gnt_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      ctrl_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            gnt_id     <= gnt_sel;
            last_grant <= gnt_sel;
            ctrl_q     <= sel_ctrl;
            a_q        <= sel_a;
            b_q        <= sel_b;
            if (reject) begin
              result_q <= '0;
              err_q    <= 1'b1;
              state    <= DONE;
            end else begin
              cnt   <= lat_m1;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            result_q <= alu_result;
            err_q    <= 1'b0;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The ALU only ever sees the latched operands, and only while executing.
  assign alu_ctrl   = (state == EXEC) ? ctrl_q : '0;
  assign alu_srcA   = (state == EXEC) ? a_q : '0;
  assign alu_srcB   = (state == EXEC) ? b_q : '0;
  assign rsp0_valid = (state == DONE) && !gnt_id;
  assign rsp1_valid = (state == DONE) && gnt_id;
  assign rsp_result = (state == DONE) ? result_q : '0;
  assign rsp_err    = (state == DONE) && err_q;
  assign busy       = (state != IDLE);
endmodule
